id_ex_decode_stage: RTL
=======================

ID_EX_DECODE_STAGE -- requirements
Module: id_ex_decode_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of pc_plus4 and branch_target.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port instruction, input, 32, MIPS word in ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0]).
REQ-005 SHALL have ports rs_data and rt_data, input, 32 each, register-file read data.
REQ-006 SHALL have port pc_plus4, input, PC_WIDTH, address of the next sequential instruction.
REQ-007 SHALL have ports valid_in, stall and flush, input, 1 each.
REQ-008 SHALL have registered outputs ALUOp (2), operation (6), operando_1 (32), operando_2 (32) feeding the ALU.
REQ-009 SHALL have registered outputs store_data (32), dest_reg (5), branch_target (PC_WIDTH).
REQ-010 SHALL have registered 1-bit outputs valid_out, reg_write, mem_read, mem_write, mem_to_reg, branch_eq, branch_ne, illegal.

Function
REQ-011 SHALL decode combinationally and present results only through the ID/EX register: latency exactly 1 clk.
REQ-012 SHALL, for opcode 000000 with funct in {000000,000010,000011,000100,000110,000111,100000-100111,101010,101011}, emit ALUOp=10, operation=funct, dest_reg=rd, reg_write=1.
REQ-013 SHALL, for funct 000000/000010/000011, drive operando_1=rt_data, operando_2=zero-extended shamt.
REQ-014 SHALL, for funct 000100/000110/000111, drive operando_1=rt_data, operando_2={27'b0, rs_data[4:0]}.
REQ-015 SHALL, for every other supported R-type funct, drive operando_1=rs_data, operando_2=rt_data.
REQ-016 SHALL decode addi/addiu (001000/001001) as ALUOp=00, operando_2=sign-extended imm, dest_reg=rt, reg_write=1.
REQ-017 SHALL decode andi/ori/xori (001100/001101/001110) as ALUOp=10, operation 100100/100101/100110, operando_2=zero-extended imm, dest_reg=rt, reg_write=1.
REQ-018 SHALL decode slti/sltiu (001010/001011) as ALUOp=10, operation 101010/101011, operando_2=sign-extended imm, dest_reg=rt, reg_write=1.
REQ-019 SHALL decode lw (100011) as ALUOp=00, operando_2=sign-extended imm, mem_read=1, mem_to_reg=1, reg_write=1, dest_reg=rt.
REQ-020 SHALL decode sw (101011) as ALUOp=00, operando_2=sign-extended imm, mem_write=1, reg_write=0, store_data=rt_data.
REQ-021 SHALL decode beq/bne (000100/000101) as ALUOp=01, operando_1=rs_data, operando_2=rt_data, branch_eq/branch_ne=1 respectively, branch_target=pc_plus4+(sign-extended imm<<2) modulo 2^PC_WIDTH.
REQ-022 SHALL set operando_1=rs_data for all I-type decodes; operation=000000 when ALUOp!=10.
REQ-023 SHALL, for any unlisted opcode or R-type funct, register illegal=1 with reg_write, mem_read, mem_write, mem_to_reg, branch_eq, branch_ne all 0.
REQ-024 SHALL force reg_write=0 whenever the decoded dest_reg is 0 (so 0x00000000 is a true bubble).
REQ-025 SHALL, on a rising edge with flush=1, load valid_out=0 and clear every control bit and illegal, regardless of stall.
REQ-026 SHALL, with flush=0 and stall=1, hold every output unchanged.
REQ-027 SHALL, with flush=0 and stall=0, load the decode; valid_out=valid_in; if valid_in=0, all control bits and illegal load 0.
REQ-028 SHALL never assert reg_write, mem_read, mem_write or branch_* while valid_out=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately drive every output to 0 (ALUOp=00, operation=000000, data and addresses all zero).
REQ-030 SHALL, on rst_n deassertion mid-stall, resume with outputs 0 until the first non-stalled, non-flushed edge.

Verification
REQ-031 add $3,$1,$2 (0x00221820), rs_data=5, rt_data=7 -> next edge: ALUOp=10, operation=100000, operando_1=5, operando_2=7, dest_reg=3, reg_write=1.
REQ-032 sra $4,$5,3 (0x000520C3), rt_data=0x80000000 -> operando_1=0x80000000, operando_2=3, operation=000011.
REQ-033 beq imm=0xFFFF, pc_plus4=0x100 -> ALUOp=01, branch_eq=1, branch_target=0xFC.
REQ-034 lw accepted with stall=1 for 3 cycles then flush=1 -> outputs held 3 cycles, then valid_out=0, mem_read=0, reg_write=0.
REQ-035 opcode 111111 -> illegal=1, all controls 0; instruction 0x00000000 -> valid_out=1, reg_write=0, illegal=0.
REQ-036 rst_n pulled low mid-cycle with valid_out=1 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_decode_stage.sv
// ID/EX pipeline stage: combinational MIPS decode registered into the EX-facing
// outputs. Flush clears valid and every control bit, stall holds the register.
module id_ex_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instruction,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                valid_in,
  input  logic                stall,
  input  logic                flush,
  output logic [1:0]          ALUOp,
  output logic [5:0]          operation,
  output logic [31:0]         operando_1,
  output logic [31:0]         operando_2,
  output logic [31:0]         store_data,
  output logic [4:0]          dest_reg,
  output logic [PC_WIDTH-1:0] branch_target,
  output logic                valid_out,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                branch_eq,
  output logic                branch_ne,
  output logic                illegal
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, br_offset;

  assign opcode    = instruction[31:26];
  assign rt        = instruction[20:16];
  assign rd        = instruction[15:11];
  assign shamt     = instruction[10:6];
  assign funct     = instruction[5:0];
  assign imm       = instruction[15:0];
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'b0, imm};
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};

  logic [1:0]          d_aluop;
  logic [5:0]          d_operation;
  logic [31:0]         d_op1, d_op2, d_store;
  logic [4:0]          d_dest;
  logic [PC_WIDTH-1:0] d_target;
  logic                d_wr, d_mrd, d_mwr, d_m2r, d_beq, d_bne, d_ill;
  logic                d_wr_gated;

  // Instruction decode; unsupported encodings fall through to illegal with all
  // controls and data left at zero.
  always_comb begin
    d_aluop     = 2'b00;
    d_operation = 6'b000000;
    d_op1       = 32'b0;
    d_op2       = 32'b0;
    d_store     = 32'b0;
    d_dest      = 5'b0;
    d_target    = '0;
    d_wr        = 1'b0;
    d_mrd       = 1'b0;
    d_mwr       = 1'b0;
    d_m2r       = 1'b0;
    d_beq       = 1'b0;
    d_bne       = 1'b0;
    d_ill       = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            d_op1 = rt_data;
            d_op2 = {27'b0, shamt};
          end
          6'b000100, 6'b000110, 6'b000111: begin
            d_op1 = rt_data;
            d_op2 = {27'b0, rs_data[4:0]};
          end
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            d_op1 = rs_data;
            d_op2 = rt_data;
          end
          default: d_ill = 1'b1;
        endcase
        if (!d_ill) begin
          d_aluop     = 2'b10;
          d_operation = funct;
          d_dest      = rd;
          d_wr        = 1'b1;
        end
      end
      6'b001000, 6'b001001: begin
        d_op1  = rs_data;
        d_op2  = imm_sext;
        d_dest = rt;
        d_wr   = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        d_aluop     = 2'b10;
        d_operation = {4'b1001, opcode[1:0]};
        d_op1       = rs_data;
        d_op2       = imm_zext;
        d_dest      = rt;
        d_wr        = 1'b1;
      end
      6'b001010, 6'b001011: begin
        d_aluop     = 2'b10;
        d_operation = {5'b10101, opcode[0]};
        d_op1       = rs_data;
        d_op2       = imm_sext;
        d_dest      = rt;
        d_wr        = 1'b1;
      end
      6'b100011: begin
        d_op1  = rs_data;
        d_op2  = imm_sext;
        d_dest = rt;
        d_wr   = 1'b1;
        d_mrd  = 1'b1;
        d_m2r  = 1'b1;
      end
      6'b101011: begin
        d_op1   = rs_data;
        d_op2   = imm_sext;
        d_store = rt_data;
        d_mwr   = 1'b1;
      end
      6'b000100, 6'b000101: begin
        d_aluop  = 2'b01;
        d_op1    = rs_data;
        d_op2    = rt_data;
        d_beq    = ~opcode[0];
        d_bne    = opcode[0];
        d_target = pc_plus4 + PC_WIDTH'($signed(br_offset));
      end
      default: d_ill = 1'b1;
    endcase
  end

  // Writes to $0 are discarded so the all-zero word is a true bubble.
  assign d_wr_gated = d_wr && (d_dest != 5'd0);

  // ID/EX register: flush beats stall; controls only ever load alongside a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUOp         <= 2'b00;
      operation     <= 6'b0;
      operando_1    <= 32'b0;
      operando_2    <= 32'b0;
      store_data    <= 32'b0;
      dest_reg      <= 5'b0;
      branch_target <= '0;
      valid_out     <= 1'b0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      branch_eq     <= 1'b0;
      branch_ne     <= 1'b0;
      illegal       <= 1'b0;
    end else if (flush || !stall) begin
      ALUOp         <= d_aluop;
      operation     <= d_operation;
      operando_1    <= d_op1;
      operando_2    <= d_op2;
      store_data    <= d_store;
      dest_reg      <= d_dest;
      branch_target <= d_target;
      valid_out     <= valid_in && !flush;
      reg_write     <= valid_in && !flush && d_wr_gated;
      mem_read      <= valid_in && !flush && d_mrd;
      mem_write     <= valid_in && !flush && d_mwr;
      mem_to_reg    <= valid_in && !flush && d_m2r;
      branch_eq     <= valid_in && !flush && d_beq;
      branch_ne     <= valid_in && !flush && d_bne;
      illegal       <= valid_in && !flush && d_ill;
    end
  end

endmodule
